// File: rtl/ofifo_drain_ctrl.sv
// Output-FIFO drain controller: reads one row at a time from the output FIFO and writes it to SRAM.
// Optional stall counter output enabled by defining OFIFO_DRAIN_STALL_CNT_EN.
//
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | waiting for ofifo_valid & !hold to issue one read
//   WAIT  | read in flight, counting down RD_LAT to data valid
//   WRITE | sram_wen high for the captured row
//   DONE  | one-cycle done pulse
module ofifo_drain_ctrl #(
    parameter int COL    = 8,
    parameter int BW     = 4,
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   num_rows,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                ofifo_valid,
    input  logic                ofifo_full,
    input  logic [COL*BW-1:0]   ofifo_data,
    input  logic                hold,
    output logic                ofifo_rd,
    output logic                sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [COL*BW-1:0]   sram_din,
    output logic                busy,
    output logic                done,
    output logic                err_full
`ifdef OFIFO_DRAIN_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   rows_q, rows_nxt;
    logic [ADDR_W-1:0]   base_q, base_nxt;
    logic [ADDR_W-1:0]   k, k_nxt, k_inc;
    logic [2:0]          cnt, cnt_nxt;
    logic                rd_nxt, wen_nxt, busy_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [COL*BW-1:0]   din_nxt;
    logic                issue_ok;

    assign issue_ok = ofifo_valid && !hold;
    assign k_inc    = k + ADDR_W'(1);

    always_comb begin
        state_nxt = state;
        rows_nxt  = rows_q;
        base_nxt  = base_q;
        k_nxt     = k;
        cnt_nxt   = cnt;
        rd_nxt    = 1'b0;
        wen_nxt   = 1'b0;
        done_nxt  = 1'b0;
        addr_nxt  = sram_addr;
        din_nxt   = sram_din;
        err_nxt   = err_full | (ofifo_full && (state == IDLE || state == DONE));
        case (state)
            IDLE: begin
                if (start) begin
                    rows_nxt  = num_rows;
                    base_nxt  = base_addr;
                    k_nxt     = '0;
                    state_nxt = (num_rows == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ok) begin
                    rd_nxt    = 1'b1;
                    cnt_nxt   = 3'(RD_LAT);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Counter reaches zero in the cycle ofifo_data is valid.
                if (cnt == 3'd0) begin
                    din_nxt   = ofifo_data;
                    addr_nxt  = base_q + k;
                    wen_nxt   = 1'b1;
                    state_nxt = WRITE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            WRITE: begin
                k_nxt     = k_inc;
                state_nxt = (k_inc == rows_q) ? DONE : ISSUE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == DONE)
            done_nxt = 1'b1;
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            rows_q    <= '0;
            base_q    <= '0;
            k         <= '0;
            cnt       <= '0;
            ofifo_rd  <= 1'b0;
            sram_wen  <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_full  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rows_q    <= rows_nxt;
            base_q    <= base_nxt;
            k         <= k_nxt;
            cnt       <= cnt_nxt;
            ofifo_rd  <= rd_nxt;
            sram_wen  <= wen_nxt;
            sram_addr <= addr_nxt;
            sram_din  <= din_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err_full  <= err_nxt;
        end
    end

`ifdef OFIFO_DRAIN_STALL_CNT_EN
    logic [15:0] stall_nxt;

    always_comb begin
        stall_nxt = stall_cnt;
        if (state == IDLE && start)
            stall_nxt = '0;
        else if (state == ISSUE && !issue_ok && stall_cnt != 16'hFFFF)
            stall_nxt = stall_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_nxt;
    end
`endif

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Directed self-checking bench for ofifo_drain_ctrl (default parameters, RD_LAT=2).
module tb_ofifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, start, ofifo_valid, ofifo_full, hold;
    logic [10:0] num_rows, base_addr;
    logic [31:0] ofifo_data;
    logic        ofifo_rd, sram_wen, busy, done, err_full;
    logic [10:0] sram_addr;
    logic [31:0] sram_din;
`ifdef OFIFO_DRAIN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    ofifo_drain_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_rows(num_rows),
        .base_addr(base_addr), .ofifo_valid(ofifo_valid), .ofifo_full(ofifo_full),
        .ofifo_data(ofifo_data), .hold(hold), .ofifo_rd(ofifo_rd), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_din(sram_din), .busy(busy), .done(done),
        .err_full(err_full)
`ifdef OFIFO_DRAIN_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: data is valid only in the cycle two cycles after the read strobe.
    logic [1:0] rd_sh = 2'b00;
    int         rd_total = 0;
    always @(posedge clk) begin
        rd_sh <= {rd_sh[0], ofifo_rd};
        if (ofifo_rd)
            rd_total <= rd_total + 1;
    end
    assign ofifo_data = rd_sh[1] ? (32'hC0DE_0000 | 32'(rd_total)) : 32'h0BAD_0BAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts with the DUT in ISSUE and ofifo_valid=1, hold=0.
    task automatic row(input logic [10:0] a, input logic [31:0] d, input bit last);
        tick(); chk("rd_issue", 32'(ofifo_rd), 1);
        tick(); chk("rd_once", 32'(ofifo_rd), 0); chk("wen_wait1", 32'(sram_wen), 0);
        tick(); chk("wen_wait2", 32'(sram_wen), 0);
        tick(); chk("wen", 32'(sram_wen), 1); chk("addr", 32'(sram_addr), 32'(a));
        chk("din", sram_din, d); chk("busy_write", 32'(busy), 1);
        tick(); chk("wen_off", 32'(sram_wen), 0); chk("addr_hold", 32'(sram_addr), 32'(a));
        chk("din_hold", sram_din, d); chk("done_flag", 32'(done), 32'(last));
        if (last) begin
            tick(); chk("done_clear", 32'(done), 0); chk("busy_idle", 32'(busy), 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; ofifo_valid = 1'b0; ofifo_full = 1'b0; hold = 1'b0;
        num_rows = '0; base_addr = '0;
        tick(); tick();
        chk("rst_rd", 32'(ofifo_rd), 0); chk("rst_wen", 32'(sram_wen), 0);
        chk("rst_addr", 32'(sram_addr), 0); chk("rst_din", sram_din, 0);
        chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_full), 0);
        reset_n = 1'b1;
        ofifo_valid = 1'b1;

        // Four rows from 0x10; a start mid-job with new parameters is ignored.
        num_rows = 11'd4; base_addr = 11'h010; start = 1'b1;
        tick(); start = 1'b0;
        chk("busy_start", 32'(busy), 1); chk("rd_first_issue", 32'(ofifo_rd), 0);
        row(11'h010, 32'hC0DE_0001, 1'b0);
        start = 1'b1; num_rows = 11'd9; base_addr = 11'h300;
        row(11'h011, 32'hC0DE_0002, 1'b0);
        start = 1'b0;
        row(11'h012, 32'hC0DE_0003, 1'b0);
        row(11'h013, 32'hC0DE_0004, 1'b1);

        // Zero rows: done on the next cycle, start during DONE ignored.
        num_rows = 11'd0; start = 1'b1;
        tick();
        chk("zero_done", 32'(done), 1); chk("zero_busy", 32'(busy), 1);
        chk("zero_rd", 32'(ofifo_rd), 0); chk("zero_wen", 32'(sram_wen), 0);
        num_rows = 11'd2;
        tick();
        chk("done_start_ign_busy", 32'(busy), 0); chk("done_start_ign_done", 32'(done), 0);
        start = 1'b0;
        tick();
        chk("still_idle", 32'(busy), 0); chk("zero_no_rd", 32'(ofifo_rd), 0);
        chk("rd_count_a", 32'(rd_total), 4);

        // Address wrap at the top of the 11-bit space.
        num_rows = 11'd3; base_addr = 11'h7FE; start = 1'b1;
        tick(); start = 1'b0;
        row(11'h7FE, 32'hC0DE_0005, 1'b0);
        row(11'h7FF, 32'hC0DE_0006, 1'b0);
        row(11'h000, 32'hC0DE_0007, 1'b1);

        // Hold for 5 ISSUE cycles; full outside IDLE/DONE does not flag; hold ignored in flight.
        num_rows = 11'd1; base_addr = 11'h055; hold = 1'b1; start = 1'b1;
        tick(); start = 1'b0; ofifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); chk("hold_no_rd", 32'(ofifo_rd), 0);
        end
        ofifo_full = 1'b0;
        chk("full_in_issue", 32'(err_full), 0);
`ifdef OFIFO_DRAIN_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 5);
`endif
        hold = 1'b0;
        tick(); chk("hold_rel_rd", 32'(ofifo_rd), 1);
        hold = 1'b1;
        tick(); tick();
        tick(); chk("hold_wen", 32'(sram_wen), 1); chk("hold_addr", 32'(sram_addr), 32'h055);
        chk("hold_din", sram_din, 32'hC0DE_0008);
        tick(); chk("hold_done", 32'(done), 1);
        tick(); hold = 1'b0;
`ifdef OFIFO_DRAIN_STALL_CNT_EN
        chk("stall_cnt_kept", 32'(stall_cnt), 5);
`endif

        // Overflow flag in IDLE is sticky across a later job.
        ofifo_full = 1'b1;
        tick(); ofifo_full = 1'b0;
        chk("err_set", 32'(err_full), 1);
        num_rows = 11'd1; base_addr = 11'h123; start = 1'b1;
        tick(); start = 1'b0;
        row(11'h123, 32'hC0DE_0009, 1'b1);
        chk("err_sticky", 32'(err_full), 1);

        // Reset in WAIT: everything clears, in-flight data never written.
        num_rows = 11'd2; base_addr = 11'h020; start = 1'b1;
        tick(); start = 1'b0;
        tick(); chk("pre_rst_rd", 32'(ofifo_rd), 1);
        reset_n = 1'b0;
        tick(); reset_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 0); chk("mid_rst_err", 32'(err_full), 0);
        chk("mid_rst_addr", 32'(sram_addr), 0); chk("mid_rst_din", sram_din, 0);
        chk("mid_rst_rd", 32'(ofifo_rd), 0); chk("mid_rst_done", 32'(done), 0);
`ifdef OFIFO_DRAIN_STALL_CNT_EN
        chk("mid_rst_stall", 32'(stall_cnt), 0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick(); chk("post_rst_wen", 32'(sram_wen), 0); chk("post_rst_busy", 32'(busy), 0);
        end
        chk("rd_count_b", 32'(rd_total), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ofifo_drain_ctrl.md
OFIFO_DRAIN_CTRL -- requirements
Module: ofifo_drain_ctrl

Interface
REQ-001 SHALL have parameters: COL, default 8, number of output-FIFO columns; BW, default 4, bits per column word; ADDR_W, default 11, SRAM address width; RD_LAT, default 2, cycles from ofifo_rd high to ofifo_data valid (legal range 1..7).
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse launching a drain job.
REQ-005 num_rows  input  ADDR_W  rows to drain, sampled on accepted start.
REQ-006 base_addr  input  ADDR_W  first SRAM address, sampled on accepted start.
REQ-007 ofifo_valid  input  1  all columns of the output FIFO non-empty.
REQ-008 ofifo_full  input  1  any output-FIFO column full.
REQ-009 ofifo_data  input  COL*BW  output-FIFO read data.
REQ-010 hold  input  1  memory busy; blocks new reads only.
REQ-011 ofifo_rd  output  1  read strobe to the output FIFO.
REQ-012 sram_wen  output  1  active-high SRAM write enable.
REQ-013 sram_addr  output  ADDR_W  SRAM write address.
REQ-014 sram_din  output  COL*BW  SRAM write data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at job completion.
REQ-017 err_full  output  1  sticky overflow flag.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, WRITE, DONE; all outputs registered.
REQ-019 IDLE: start=1 latches num_rows/base_addr, clears row count k; next state ISSUE, or DONE if num_rows=0.
REQ-020 start while busy=1 SHALL be ignored with no side effects.
REQ-021 ISSUE: when ofifo_valid=1 and hold=0, assert ofifo_rd for exactly one cycle, load wait counter with RD_LAT, go WAIT; otherwise stay, ofifo_rd=0.
REQ-022 At most one read outstanding; ofifo_rd never asserted outside ISSUE.
REQ-023 WAIT: decrement counter each cycle; in the cycle ofifo_data is valid (RD_LAT cycles after ofifo_rd), capture it into sram_din and go WRITE.
REQ-024 WRITE: sram_wen=1 for one cycle, sram_addr=(base_addr+k) mod 2^ADDR_W (wraps silently), k increments; then DONE if k+1=num_rows, else ISSUE.
REQ-025 Write latency: sram_wen rises RD_LAT+1 cycles after the matching ofifo_rd; hold does not delay in-flight writes.
REQ-026 DONE: done=1 one cycle, then IDLE; start in DONE ignored.
REQ-027 err_full SHALL set when ofifo_full=1 while state is IDLE or DONE, hold until reset.
REQ-028 sram_addr and sram_din SHALL hold last values when sram_wen=0.

Reset
REQ-029 reset_n=0 at a rising edge SHALL force IDLE, k=0, ofifo_rd=0, sram_wen=0, sram_addr=0, sram_din=0, busy=0, done=0, err_full=0, regardless of state; in-flight read data is discarded.

Configuration
REQ-030 Macro OFIFO_DRAIN_STALL_CNT_EN defined: add output stall_cnt (16 bits), cleared by reset and accepted start, incremented (saturating at 0xFFFF) each ISSUE cycle with ofifo_rd=0.
REQ-031 Macro undefined: no stall_cnt port or logic; all other behaviour identical.

Verification
REQ-032 reset_n=0 mid-WAIT -> next cycle all outputs 0, state IDLE, no sram_wen afterward.
REQ-033 num_rows=4, base_addr=0x10, ofifo_valid=1, hold=0, RD_LAT=2 -> writes to 0x10..0x13 each 3 cycles after its ofifo_rd, done pulse after 4th write.
REQ-034 num_rows=0 start -> done one cycle later, no ofifo_rd, no sram_wen.
REQ-035 base_addr=0x7FE, num_rows=3, ADDR_W=11 -> addresses 0x7FE, 0x7FF, 0x000.
REQ-036 hold=1 for 5 cycles in ISSUE, ofifo_valid=1 -> no ofifo_rd during hold, read issued first cycle hold=0; with macro, stall_cnt=5.
REQ-037 ofifo_full=1 in IDLE -> err_full=1 next cycle, remains 1 through a later job until reset.
